// File: rtl/qmult_pkg.sv
// Shared sizing helpers and the magnitude round/saturate function used by the
// coefficient multipliers and the kernel adder tree.
package qmult_pkg;

  // Widest accumulator the round/saturate helper handles.
  localparam int MAX_W = 128;

  typedef struct packed {
    logic [MAX_W-1:0] mag;
    logic             ovf;
  } rsat_t;

  function automatic int PROD_W(input int pix_w, input int word_w);
    return pix_w + word_w - 1;
  endfunction

  function automatic logic [MAX_W-1:0] MAG_MAX(input int word_w);
    return (MAX_W'(1) << (word_w - 1)) - MAX_W'(1);
  endfunction

  // Round half up on the magnitude, then clamp to the largest word magnitude.
  function automatic rsat_t round_sat(input logic [MAX_W-1:0] p, input int shift,
                                      input int word_w);
    logic [MAX_W-1:0] m;
    logic [MAX_W-1:0] lim;
    rsat_t            r;
    if (shift > 0) begin
      m = (p + (MAX_W'(1) << (shift - 1))) >> shift;
    end else begin
      m = p;
    end
    lim = MAG_MAX(word_w);
    if (m > lim) begin
      r.mag = lim;
      r.ovf = 1'b1;
    end else begin
      r.mag = m;
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/qmult_stage.sv
// One shift-add stage: adds the coefficient magnitude shifted by STAGE when
// pixel bit STAGE is set, and carries pixel, magnitude and sign forward.
module qmult_stage
  import qmult_pkg::*;
#(
  parameter int STAGE     = 0,
  parameter int PIX_WIDTH = 8,
  parameter int MAG_W     = 31,
  parameter int ACC_W     = PROD_W(PIX_WIDTH, MAG_W + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 prev_valid,
  input  logic [PIX_WIDTH-1:0] prev_pix,
  input  logic [MAG_W-1:0]     prev_mag,
  input  logic                 prev_sign,
  input  logic [ACC_W-1:0]     prev_partial,
  output logic                 valid,
  output logic [PIX_WIDTH-1:0] pix,
  output logic [MAG_W-1:0]     mag,
  output logic                 sign,
  output logic [ACC_W-1:0]     partial
);

  logic [ACC_W-1:0] addend;

  always_comb begin
    addend = '0;
    if (prev_pix[STAGE]) begin
      addend = ACC_W'(prev_mag) << STAGE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
    end else if (en) begin
      valid <= prev_valid;
    end
  end

  // Data registers follow the enable only; bubbles carry don't-care data.
  always_ff @(posedge clk) begin
    if (en) begin
      pix     <= prev_pix;
      mag     <= prev_mag;
      sign    <= prev_sign;
      partial <= prev_partial + addend;
    end
  end

endmodule

// File: rtl/qmult_pipe.sv
// Pipelined shift-add multiplier: unsigned pixel times sign-magnitude
// coefficient, with valid/ready backpressure, rounding shift and saturation.
module qmult_pipe
  import qmult_pkg::*;
#(
  parameter int PIX_WIDTH      = 8,
  parameter int FP_WORD_LENGTH = 32,
  parameter int FP_FRAC_LENGTH = 15,
  parameter int OUT_SHIFT      = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PIX_WIDTH-1:0]      pix,
  input  logic [FP_WORD_LENGTH-1:0] coef,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FP_WORD_LENGTH-1:0] y,
  output logic                      ovf
);

  localparam int MAG_W = FP_WORD_LENGTH - 1;
  localparam int ACC_W = PROD_W(PIX_WIDTH, FP_WORD_LENGTH);

  if (OUT_SHIFT < 0 || OUT_SHIFT > PIX_WIDTH + FP_WORD_LENGTH - 2) begin : g_bad_shift
    $error("qmult_pipe: OUT_SHIFT out of range");
  end
  if (FP_FRAC_LENGTH < 0 || FP_FRAC_LENGTH >= FP_WORD_LENGTH) begin : g_bad_frac
    $error("qmult_pipe: FP_FRAC_LENGTH must leave room for the sign bit");
  end
  if (ACC_W > MAX_W) begin : g_bad_width
    $error("qmult_pipe: accumulator wider than round_sat supports");
  end

  logic en;

  // Whole pipeline advances together; it only stalls when a result is waiting.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic                 vld_p  [0:PIX_WIDTH];
  logic [PIX_WIDTH-1:0] pix_p  [0:PIX_WIDTH];
  logic [MAG_W-1:0]     mag_p  [0:PIX_WIDTH];
  logic                 sign_p [0:PIX_WIDTH];
  logic [ACC_W-1:0]     part_p [0:PIX_WIDTH];

  assign vld_p[0]  = in_valid;
  assign pix_p[0]  = pix;
  assign mag_p[0]  = coef[FP_WORD_LENGTH-2:0];
  assign sign_p[0] = coef[FP_WORD_LENGTH-1];
  assign part_p[0] = '0;

  for (genvar i = 0; i < PIX_WIDTH; i++) begin : g_stage
    qmult_stage #(
      .STAGE     (i),
      .PIX_WIDTH (PIX_WIDTH),
      .MAG_W     (MAG_W),
      .ACC_W     (ACC_W)
    ) u_stage (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .prev_valid   (vld_p[i]),
      .prev_pix     (pix_p[i]),
      .prev_mag     (mag_p[i]),
      .prev_sign    (sign_p[i]),
      .prev_partial (part_p[i]),
      .valid        (vld_p[i+1]),
      .pix          (pix_p[i+1]),
      .mag          (mag_p[i+1]),
      .sign         (sign_p[i+1]),
      .partial      (part_p[i+1])
    );
  end

  rsat_t            rs;
  logic [MAG_W-1:0] mag_fin;

  always_comb begin
    rs      = round_sat(MAX_W'(part_p[PIX_WIDTH]), OUT_SHIFT, FP_WORD_LENGTH);
    mag_fin = rs.mag[MAG_W-1:0];
  end

  // Output stage: y/ovf only load on a valid entry so they stay put across
  // bubbles and stalls; a zero magnitude never carries a sign.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      y         <= '0;
      ovf       <= 1'b0;
    end else if (en) begin
      out_valid <= vld_p[PIX_WIDTH];
      if (vld_p[PIX_WIDTH]) begin
        y   <= {sign_p[PIX_WIDTH] && (mag_fin != '0), mag_fin};
        ovf <= rs.ovf;
      end
    end
  end

endmodule

// File: tb/tb_qmult_pipe.sv
// Bench for qmult_pipe: two instances (OUT_SHIFT 0 and 3) fed the same stream,
// table vectors, random backpressured stream and a mid-stream reset.
module tb_qmult_pipe;

  typedef struct {
    logic [7:0]  pix;
    logic [31:0] coef;
    logic [31:0] y0;
    logic        ovf0;
    logic [31:0] y3;
    logic        ovf3;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] y0;
    logic        ovf0;
    logic [31:0] y3;
    logic        ovf3;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  pix;
  logic [31:0] coef;
  logic        out_ready;
  logic        in_ready0, in_ready3;
  logic        out_valid0, out_valid3;
  logic [31:0] y0, y3;
  logic        ovf0, ovf3;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sbq[$];
  vec_t tbl[10];

  always #5 clk = ~clk;

  qmult_pipe #(.PIX_WIDTH(8), .FP_WORD_LENGTH(32), .FP_FRAC_LENGTH(15), .OUT_SHIFT(0)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .pix(pix),
    .coef(coef), .out_valid(out_valid0), .out_ready(out_ready), .y(y0), .ovf(ovf0)
  );

  qmult_pipe #(.PIX_WIDTH(8), .FP_WORD_LENGTH(32), .FP_FRAC_LENGTH(15), .OUT_SHIFT(3)) u_dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3), .pix(pix),
    .coef(coef), .out_valid(out_valid3), .out_ready(out_ready), .y(y3), .ovf(ovf3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  function automatic void calc(input logic [7:0] p, input logic [31:0] c, input int s,
                               output logic [31:0] yv, output logic ov);
    longint unsigned prod, m;
    prod = longint'(p) * longint'(c[30:0]);
    m    = (s > 0) ? ((prod + (64'd1 << (s - 1))) >> s) : prod;
    if (m > 64'h7FFF_FFFF) begin
      m  = 64'h7FFF_FFFF;
      ov = 1'b1;
    end else begin
      ov = 1'b0;
    end
    yv = {c[31] && (m != 0), m[30:0]};
  endfunction

  function automatic exp_t model(input int id, input logic [7:0] p, input logic [31:0] c);
    exp_t e;
    e.id = id;
    calc(p, c, 0, e.y0, e.ovf0);
    calc(p, c, 3, e.y3, e.ovf3);
    return e;
  endfunction

  // Scoreboard consumer plus stall-stability checks, sampled on the falling edge.
  bit          stalled_prev = 1'b0;
  logic [31:0] y_prev;
  int          unexpected = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid0 !== out_valid3) chk("out_valid_pair", out_valid3, out_valid0);
      if (out_valid0 && out_ready) begin
        if (sbq.size() == 0) begin
          unexpected++;
          chk("unexpected_output", y0, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk($sformatf("y_s0[%0d]", e.id), y0, e.y0);
          chk($sformatf("ovf_s0[%0d]", e.id), ovf0, e.ovf0);
          chk($sformatf("y_s3[%0d]", e.id), y3, e.y3);
          chk($sformatf("ovf_s3[%0d]", e.id), ovf3, e.ovf3);
        end
      end
      if (out_valid0 && !out_ready) begin
        chk("stall_in_ready", in_ready0, 0);
        if (stalled_prev) chk("stall_y_stable", y0, y_prev);
      end
    end
    stalled_prev = !reset && out_valid0 && !out_ready;
    y_prev       = y0;
  end

  task automatic send(input logic [7:0] p, input logic [31:0] c, input exp_t e);
    bit ok = 1'b0;
    in_valid = 1'b1;
    pix      = p;
    coef     = c;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (in_ready0) begin
        sbq.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sbq.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, sbq.size(), 0);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_out_valid0"}, out_valid0, 0);
    chk({name, "_y0"}, y0, 0);
    chk({name, "_ovf0"}, ovf0, 0);
    chk({name, "_out_valid3"}, out_valid3, 0);
    chk({name, "_y3"}, y3, 0);
    chk({name, "_ovf3"}, ovf3, 0);
  endtask

  task automatic latency_check(input string name, input int idx);
    int n = 1;
    send(tbl[idx].pix, tbl[idx].coef,
         '{idx, tbl[idx].y0, tbl[idx].ovf0, tbl[idx].y3, tbl[idx].ovf3});
    while (!out_valid0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, n, 9);
  endtask

  initial begin
    tbl[0] = '{8'd200, 32'h0000_8000, 32'h0064_0000, 1'b0, 32'h000C_8000, 1'b0};
    tbl[1] = '{8'd255, 32'h8000_4000, 32'h803F_C000, 1'b0, 32'h8007_F800, 1'b0};
    tbl[2] = '{8'd0,   32'h8000_4000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    tbl[3] = '{8'd255, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1};
    tbl[4] = '{8'd255, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    tbl[5] = '{8'd1,   32'h0000_0004, 32'h0000_0004, 1'b0, 32'h0000_0001, 1'b0};
    tbl[6] = '{8'd1,   32'h0000_0003, 32'h0000_0003, 1'b0, 32'h0000_0000, 1'b0};
    tbl[7] = '{8'd1,   32'h8000_000C, 32'h8000_000C, 1'b0, 32'h8000_0002, 1'b0};
    tbl[8] = '{8'd1,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'h1000_0000, 1'b0};
    tbl[9] = '{8'd2,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'h2000_0000, 1'b0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    pix       = '0;
    coef      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    reset = 1'b0;

    latency_check("latency_basic", 0);
    drain("drain_basic");

    for (int i = 0; i < 10; i++) begin
      send(tbl[i].pix, tbl[i].coef, '{i, tbl[i].y0, tbl[i].ovf0, tbl[i].y3, tbl[i].ovf3});
    end
    drain("drain_table");

    // Random stream with a 5-cycle downstream stall while results are flowing.
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          logic [7:0]  p;
          logic [31:0] c;
          p = 8'($urandom);
          c = $urandom;
          if (i % 2 == 1) c[30:18] = '0;
          send(p, c, model(100 + i, p, c));
        end
      end
      begin
        repeat (12) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_stream");

    // Mid-stream reset: six items in flight are discarded.
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].pix, tbl[i].coef, '{200 + i, tbl[i].y0, tbl[i].ovf0, tbl[i].y3, tbl[i].ovf3});
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sbq.delete();
    chk_idle("midreset");
    begin
      int seen = 0;
      repeat (12) begin
        @(posedge clk);
        #1;
        if (out_valid0 || out_valid3) seen++;
      end
      chk("midreset_flushed", seen, 0);
    end
    latency_check("latency_after_reset", 1);
    drain("drain_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/qmult_pipe.md
Name: qmult_pipe

Overview:
- Parametrised, fully pipelined shift-add multiplier: unsigned pixel × sign-magnitude fixed-point coefficient.
- Successor to the fixed 8-bit, always-enabled coefficient multiplier. Adds generic pixel width, per-stage valid tracking, valid/ready backpressure, optional right-shift normalisation with rounding, output saturation and an overflow flag.
- Sits in the avalon 3x3 filter datapath between the pixel window buffer and the kernel adder tree; one instance per kernel tap.

Parameters:
- PIX_WIDTH, 8, unsigned pixel width. Also the number of shift-add stages.
- FP_WORD_LENGTH, 32, coefficient/result word. MSB is the sign, the rest is the magnitude.
- FP_FRAC_LENGTH, 15, fractional bits of the coefficient and result. Documentation only; the arithmetic is Q-format agnostic.
- OUT_SHIFT, 0, right shift applied to the product magnitude before saturation, for kernel normalisation. Range 0..PIX_WIDTH+FP_WORD_LENGTH-2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  pix/coef valid
- in_ready  out  1  pipeline accepts an input this cycle
- pix  in  PIX_WIDTH  unsigned pixel (integer)
- coef  in  FP_WORD_LENGTH  sign-magnitude coefficient
- out_valid  out  1  y/ovf valid
- out_ready  in  1  downstream accepts y
- y  out  FP_WORD_LENGTH  sign-magnitude result
- ovf  out  1  result was saturated

Behaviour:
- Reset: one clock; synchronous and active-high. All stage valid bits clear; out_valid=0, y=0, ovf=0. In-flight data is discarded. Data registers need no reset.
- Transfer rules:
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
- Advance enable: en = !out_valid || out_ready. in_ready = en (combinational).
  - When en=0 every stage holds, including valid bits and data.
  - When en=1 every stage shifts by one.
  - Bubbles travel as valid=0 entries; there is no compaction.
- Stage i (0..PIX_WIDTH-1):
  - partial_i = partial_{i-1} + (pix_bit_i ? mag << i : 0), with mag = coef[FP_WORD_LENGTH-2:0].
  - pix, mag and sign are carried forward in each stage.
- Accumulator width: PROD_W = PIX_WIDTH+FP_WORD_LENGTH-1 bits; the accumulator never wraps.
- Output stage (stage PIX_WIDTH):
  - If OUT_SHIFT>0: m = (P + 2^(OUT_SHIFT-1)) >> OUT_SHIFT, i.e. round half up on the magnitude, so symmetric about zero. Otherwise m = P.
  - If m > MAG_MAX = 2^(FP_WORD_LENGTH-1)-1: magnitude = MAG_MAX, ovf=1. Otherwise magnitude = m[FP_WORD_LENGTH-2:0], ovf=0.
  - Sign bit = coef sign, except it is forced to 0 when the final magnitude is 0 (no negative zero).
- Latency: PIX_WIDTH+1 enabled cycles from accept to out_valid. With OUT_SHIFT=0, PIX_WIDTH=8 this is 9 cycles.
- Throughput: 1 result per cycle while out_ready=1.
- Ordering is strictly preserved.
- Stall boundary: while out_valid=1 && out_ready=0, in_ready=0 and y/ovf stay stable. A same-cycle accept and consume is legal.
- Reset has priority over any simultaneous handshake.

Decomposition:
- Package qmult_pkg holds:
  - localparam functions PROD_W(pix_w, word_w) and MAG_MAX(word_w).
  - A round/saturate function (shift, round half up, clamp) reused by the adder tree.
- Sub-module qmult_stage: one shift-add stage.
  - Parameters: stage index, widths.
  - Ports: clk, reset, en, valid/pix/mag/sign/partial in and out.
  - Instantiated PIX_WIDTH times via generate. The output stage stays in qmult_pipe.

Test Plan (W=32, F=15, PIX_WIDTH=8 unless noted):
- Basic: pix=200, coef=0x00008000 (1.0), OUT_SHIFT=0, out_ready=1 -> y=0x00640000, ovf=0, out_valid exactly 9 cycles after accept.
- Sign and zero:
  - pix=255, coef=0x80004000 (-0.5) -> y=0x803FC000.
  - pix=0, coef=0x80004000 -> y=0x00000000 (sign cleared).
- Saturation:
  - pix=255, coef=0x7FFFFFFF -> y=0x7FFFFFFF, ovf=1.
  - pix=255, coef=0xFFFFFFFF -> y=0xFFFFFFFF, ovf=1.
- Rounding, OUT_SHIFT=3:
  - pix=1, coef=0x00000004 -> y=0x00000001.
  - pix=1, coef=0x00000003 -> y=0x00000000.
  - pix=1, coef=0x8000000C -> y=0x80000002.
- Backpressure: 20-item random stream with out_ready held low 5 cycles mid-stream -> no loss or duplication, order preserved, in_ready=0 and y stable during the stall, results match the reference model.
- Reset mid-stream: assert reset for 1 cycle with 6 items in flight -> out_valid=0, y=0, ovf=0 the next cycle; none of the 6 ever appear; the next accepted item emerges after 9 cycles.
